// File: rtl/pci_mem_target.sv
// 32-bit PCI target: Type-0 config header plus one memory BAR over an NREGS x 32 register file.
// Optional PCI_PARITY_EN: read parity generation, write parity checking and PERR# reporting.
module pci_mem_target #(
  parameter int          NREGS     = 16,
  parameter logic [15:0] VENDOR_ID = 16'h1172,
  parameter logic [15:0] DEVICE_ID = 16'h0001,
  parameter logic [31:0] CLASS_REV = 32'hFF000000
) (
  input  logic        PCI_CLK,
  input  logic        RST,
  input  logic [31:0] AD_IN,
  input  logic [3:0]  CBE_IN,
  input  logic        FRAME_N_IN,
  input  logic        IRDY_N_IN,
  input  logic        IDSEL_IN,
  input  logic        PAR_IN,
  output logic [31:0] AD_OUT,
  output logic        AD_OE,
  output logic        TRDY_N_OUT,
  output logic        DEVSEL_N_OUT,
  output logic        STOP_N_OUT,
  output logic        TRGT_OE,
  output logic        PAR_OUT,
  output logic        PAR_OE,
  output logic        PERR_N_OUT,
  output logic        PERR_OE,
  output logic [31:0] USER_REG0,
  output logic [1:0]  STATE_DBG
);
  localparam int          IW       = $clog2(NREGS);
  localparam int          AW       = IW + 2;
  localparam logic [31:0] BAR_MASK = 32'hFFFF_FFFF << AW;

  typedef enum logic [1:0] {IDLE, S_DATA, TURN_AR, BUSY} state_t;
  state_t state, state_nx;

  logic [31:0]   regs [NREGS];
  logic [31:0]   bar0, cfg_rdata, rd_word;
  logic          cmd_mem_en, cmd_par_resp, perr_stat, perr_hit;
  logic          frame_n_q, is_read, is_cfg, misalign, rd_first, disc_wait;
  logic [IW-1:0] idx, idx_sel;
  logic [5:0]    cfg_dw;
  logic          addr_phase, cfg_hit, mem_rd, mem_wr, mem_hit, a_read, a_stop, done, sel_stop;

  // Handshake: a data phase completes on any edge where IRDY# and TRDY# are both low.
  always_comb begin
    addr_phase = (state == IDLE) && frame_n_q && !FRAME_N_IN;
    cfg_hit    = IDSEL_IN && (CBE_IN == 4'hA || CBE_IN == 4'hB) && (AD_IN[1:0] == 2'b00);
    mem_rd     = (CBE_IN == 4'h6) || (CBE_IN == 4'hC) || (CBE_IN == 4'hE);
    mem_wr     = (CBE_IN == 4'h7) || (CBE_IN == 4'hF);
    mem_hit    = cmd_mem_en && (mem_rd || mem_wr) && (AD_IN[31:AW] == bar0[31:AW]);
    a_read     = cfg_hit ? !CBE_IN[0] : mem_rd;
    a_stop     = cfg_hit || (AD_IN[1:0] != 2'b00) || (&AD_IN[AW-1:2]);
    done       = (state == S_DATA) && !IRDY_N_IN && !TRDY_N_OUT;
    idx_sel    = done ? idx + 1'b1 : idx;
    sel_stop   = is_cfg || misalign || (&idx_sel);
    cfg_rdata  = '0;
    case (cfg_dw)
      6'd0:    cfg_rdata = {DEVICE_ID, VENDOR_ID};
      6'd1:    cfg_rdata = {perr_stat, 15'd0, 9'd0, cmd_par_resp, 4'd0, cmd_mem_en, 1'b0};
      6'd2:    cfg_rdata = CLASS_REV;
      6'd4:    cfg_rdata = bar0;
      default: cfg_rdata = '0;
    endcase
    rd_word  = is_cfg ? cfg_rdata : regs[idx_sel];
    state_nx = state;
    case (state)
      IDLE:    if (addr_phase) state_nx = (cfg_hit || mem_hit) ? S_DATA : BUSY;
      S_DATA:  if ((done || disc_wait) && FRAME_N_IN) state_nx = TURN_AR;
      TURN_AR: state_nx = IDLE;
      BUSY:    if (FRAME_N_IN && IRDY_N_IN) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge PCI_CLK) begin
    if (RST) begin
      state <= IDLE;  frame_n_q <= 1'b1;
      TRGT_OE <= 1'b0; AD_OE <= 1'b0; AD_OUT <= '0;
      TRDY_N_OUT <= 1'b1; DEVSEL_N_OUT <= 1'b1; STOP_N_OUT <= 1'b1;
      is_read <= 1'b0; is_cfg <= 1'b0; misalign <= 1'b0; rd_first <= 1'b0; disc_wait <= 1'b0;
      idx <= '0; cfg_dw <= '0;
    end else begin
      state     <= state_nx;
      frame_n_q <= FRAME_N_IN;
      case (state)
        IDLE: if (addr_phase && (cfg_hit || mem_hit)) begin
          TRGT_OE <= 1'b1; DEVSEL_N_OUT <= 1'b0;
          is_cfg <= cfg_hit; is_read <= a_read; misalign <= (AD_IN[1:0] != 2'b00);
          idx <= AD_IN[AW-1:2]; cfg_dw <= AD_IN[7:2];
          rd_first <= a_read; disc_wait <= 1'b0;
          if (a_read) AD_OE <= 1'b1;
          else begin
            TRDY_N_OUT <= 1'b0; STOP_N_OUT <= !a_stop;
          end
        end
        S_DATA: begin
          if (rd_first) begin
            // Turnaround cycle is over: present the first word.
            rd_first <= 1'b0; TRDY_N_OUT <= 1'b0; AD_OUT <= rd_word; STOP_N_OUT <= !sel_stop;
          end else if (done && FRAME_N_IN) begin
            TRDY_N_OUT <= 1'b1; DEVSEL_N_OUT <= 1'b1; STOP_N_OUT <= 1'b1; AD_OE <= 1'b0;
          end else if (done && !STOP_N_OUT) begin
            TRDY_N_OUT <= 1'b1; disc_wait <= 1'b1;
          end else if (done) begin
            idx <= idx_sel; STOP_N_OUT <= !sel_stop;
            if (is_read) AD_OUT <= rd_word;
          end else if (disc_wait && FRAME_N_IN) begin
            TRDY_N_OUT <= 1'b1; DEVSEL_N_OUT <= 1'b1; STOP_N_OUT <= 1'b1; AD_OE <= 1'b0;
          end
        end
        TURN_AR: TRGT_OE <= 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge PCI_CLK) begin
    if (RST) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      bar0 <= '0; cmd_mem_en <= 1'b0; cmd_par_resp <= 1'b0; perr_stat <= 1'b0;
    end else begin
      if (done && !is_read && !is_cfg)
        for (int b = 0; b < 4; b++)
          if (!CBE_IN[b]) regs[idx][8*b +: 8] <= AD_IN[8*b +: 8];
      if (done && !is_read && is_cfg) begin
        case (cfg_dw)
          6'd1: begin
            if (!CBE_IN[0]) begin
              cmd_mem_en <= AD_IN[1]; cmd_par_resp <= AD_IN[6];
            end
            if (!CBE_IN[3] && AD_IN[31]) perr_stat <= 1'b0;
          end
          6'd4:
            for (int b = 0; b < 4; b++)
              if (!CBE_IN[b]) bar0[8*b +: 8] <= AD_IN[8*b +: 8] & BAR_MASK[8*b +: 8];
          default: ;
        endcase
      end
      if (perr_hit) perr_stat <= 1'b1;
    end
  end

`ifdef PCI_PARITY_EN
  logic        wr_chk;
  logic [31:0] ad_q;
  logic [3:0]  cbe_q;

  // PAR for a write phase arrives one cycle later, so the captured AD/CBE are checked on the next edge.
  assign perr_hit = wr_chk && (PAR_IN != ^{ad_q, cbe_q});

  always_ff @(posedge PCI_CLK) begin
    if (RST) begin
      PAR_OUT <= 1'b0; PAR_OE <= 1'b0; PERR_N_OUT <= 1'b1; PERR_OE <= 1'b0;
      wr_chk <= 1'b0; ad_q <= '0; cbe_q <= '0;
    end else begin
      if (AD_OE) PAR_OUT <= ^{AD_OUT, CBE_IN};
      PAR_OE     <= AD_OE;
      wr_chk     <= done && !is_read;
      ad_q       <= AD_IN;
      cbe_q      <= CBE_IN;
      PERR_N_OUT <= !(perr_hit && cmd_par_resp);
      PERR_OE    <= (perr_hit && cmd_par_resp) || !PERR_N_OUT;
    end
  end
`else
  logic unused_par;
  assign unused_par = PAR_IN;
  assign perr_hit   = 1'b0;
  assign PAR_OUT    = 1'b0;
  assign PAR_OE     = 1'b0;
  assign PERR_N_OUT = 1'b1;
  assign PERR_OE    = 1'b0;
`endif

  assign USER_REG0 = regs[0];
  assign STATE_DBG = state;
endmodule

// File: tb/tb_pci_mem_target.sv
// Bench for pci_mem_target: a bus-master task drives PCI transactions; read data is scored against exp_q.
module tb_pci_mem_target;
  logic        clk = 1'b0;
  logic        rst, frame_n, irdy_n, idsel_in, par_in;
  logic [31:0] ad_in, ad_out, user_reg0;
  logic [3:0]  cbe_in;
  logic        ad_oe, trdy_n_out, devsel_n_out, stop_n_out, trgt_oe;
  logic        par_out, par_oe, perr_n_out, perr_oe;
  logic [1:0]  state_dbg;

  int          n_checks = 0, n_pass = 0;
  logic [31:0] exp_q[$];
  logic [31:0] wr_q[$];
  logic [31:0] model [16];
  logic        par_flip = 1'b0;
  int          r_done, r_stop, r_first, r_last;
  logic        r_claim;
  logic [2:0]  r_a1;

  pci_mem_target dut (
    .PCI_CLK(clk), .RST(rst), .AD_IN(ad_in), .CBE_IN(cbe_in), .FRAME_N_IN(frame_n),
    .IRDY_N_IN(irdy_n), .IDSEL_IN(idsel_in), .PAR_IN(par_in), .AD_OUT(ad_out), .AD_OE(ad_oe),
    .TRDY_N_OUT(trdy_n_out), .DEVSEL_N_OUT(devsel_n_out), .STOP_N_OUT(stop_n_out),
    .TRGT_OE(trgt_oe), .PAR_OUT(par_out), .PAR_OE(par_oe), .PERR_N_OUT(perr_n_out),
    .PERR_OE(perr_oe), .USER_REG0(user_reg0), .STATE_DBG(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  // One bus cycle; PAR_IN follows the AD/CBE of the cycle just ended.
  task automatic tick();
    logic p;
    p = (^{ad_in, cbe_in}) ^ par_flip;
    @(posedge clk); #1;
    par_in = p;
  endtask

  task automatic pci_access(input logic [3:0] cmd, input logic [31:0] addr, input logic idsel,
                            input int n, input logic [3:0] be, input int rst_at);
    logic is_wr, fin, frame_nx;
    int   cyc;
    is_wr = cmd[0]; fin = 1'b0; cyc = 0; frame_nx = (n == 1);
    r_done = 0; r_stop = 0; r_first = -1; r_last = -1; r_claim = 1'b0; r_a1 = '0;
    frame_n = 1'b0; ad_in = addr; cbe_in = cmd; idsel_in = idsel; irdy_n = 1'b1;
    tick();
    idsel_in = 1'b0; irdy_n = 1'b0; cbe_in = be;
    r_a1 = {trgt_oe, devsel_n_out, ad_oe};
    while (!fin) begin
      frame_n = frame_nx;
      ad_in = (is_wr && wr_q.size() > 0) ? wr_q[0] : 32'h0;
      if (trgt_oe || !devsel_n_out) r_claim = 1'b1;
      if (rst_at > 0 && r_done == rst_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_oe", 32'({ad_oe, trgt_oe, par_oe, perr_oe}), 32'h0);
        check("rst_mid_ctl", 32'({trdy_n_out, devsel_n_out, stop_n_out}), 32'h7);
        frame_nx = 1'b1; frame_n = 1'b1; irdy_n = 1'b1; fin = 1'b1;
      end else if (!trdy_n_out) begin
        if (r_first < 0) r_first = cyc;
        r_last = cyc;
        r_done++;
        if (!is_wr) begin
          if (exp_q.size() == 0) check("rd_underflow", 32'(exp_q.size()), 32'h1);
          else check("rd_data", ad_out, exp_q.pop_front());
        end else if (wr_q.size() > 0) void'(wr_q.pop_front());
        if (!stop_n_out && r_stop == 0) r_stop = r_done;
        if (frame_n) fin = 1'b1;
        else if (!stop_n_out || r_done == n - 1) frame_nx = 1'b1;
      end else if (!stop_n_out || (!r_claim && cyc >= 4)) begin
        if (frame_n) fin = 1'b1;
        else frame_nx = 1'b1;
      end
      tick();
      cyc++;
      if (cyc > 40) begin
        check("timeout", 32'(cyc), 32'h0);
        fin = 1'b1;
      end
    end
    irdy_n = 1'b1; frame_n = 1'b1; ad_in = '0; cbe_in = '0;
    wr_q.delete();
    tick();
  endtask

  task automatic cfg_wr(input logic [5:0] dw, input logic [31:0] data);
    wr_q.push_back(data);
    pci_access(4'hB, {24'h0, dw, 2'b00}, 1'b1, 1, 4'h0, 0);
  endtask

  task automatic cfg_rd(input logic [5:0] dw, input logic [31:0] exp);
    exp_q.push_back(exp);
    pci_access(4'hA, {24'h0, dw, 2'b00}, 1'b1, 1, 4'h0, 0);
  endtask

  task automatic mem_wr(input int i, input logic [31:0] data, input logic [3:0] be);
    wr_q.push_back(data);
    pci_access(4'h7, 32'h8000_0000 + 32'(i * 4), 1'b0, 1, be, 0);
    for (int b = 0; b < 4; b++) if (!be[b]) model[i][8*b +: 8] = data[8*b +: 8];
  endtask

  initial begin
    for (int i = 0; i < 16; i++) model[i] = '0;
    rst = 1'b1; frame_n = 1'b1; irdy_n = 1'b1; idsel_in = 1'b0; ad_in = '0; cbe_in = '0; par_in = 1'b0;
    repeat (3) tick();
    check("rst_oe", 32'({ad_oe, trgt_oe, par_oe, perr_oe}), 32'h0);
    check("rst_ctl", 32'({trdy_n_out, devsel_n_out, stop_n_out, perr_n_out}), 32'hF);
    check("rst_ad", ad_out, 32'h0);
    check("rst_user", user_reg0, 32'h0);
    rst = 1'b0;
    tick();

    // BAR sizing and header contents
    cfg_wr(6'd4, 32'hFFFF_FFFF);
    check("cfg_wr_done", 32'(r_done), 32'd1);
    check("cfg_wr_stop", 32'(r_stop), 32'd1);
    cfg_rd(6'd4, 32'hFFFF_FFC0);
    check("cfg_rd_stop", 32'(r_stop), 32'd1);
    check("cfg_rd_lat", 32'(r_first), 32'd1);
    cfg_rd(6'd0, 32'h0001_1172);
    cfg_rd(6'd2, 32'hFF00_0000);
    cfg_rd(6'd3, 32'h0);
    cfg_wr(6'd4, 32'h8000_0000);
    cfg_wr(6'd1, 32'h0000_0002);
    cfg_rd(6'd1, 32'h0000_0002);
    cfg_rd(6'd4, 32'h8000_0000);

    // 4-word write burst at the region end disconnects after word index 15
    wr_q = '{32'hFFFF_FFFF, 32'h1234_5678, 32'hDEAD_BEEF, 32'h0BAD_F00D};
    pci_access(4'h7, 32'h8000_0038, 1'b0, 4, 4'h0, 0);
    model[14] = 32'hFFFF_FFFF; model[15] = 32'h1234_5678;
    check("wrb_done", 32'(r_done), 32'd2);
    check("wrb_stop", 32'(r_stop), 32'd2);
    check("wrb_a1", 32'(r_a1), 32'b100);
    check("wrb_lat", 32'(r_first), 32'd0);

    mem_wr(0, 32'h0000_00A5, 4'h0);
    mem_wr(1, 32'h1122_3344, 4'h0);
    mem_wr(1, 32'hAABB_CCDD, 4'b1010);
    check("user_reg0", 32'(user_reg0[7:0]), 32'h0000_00A5);

    // 3-word read burst, zero wait states
    for (int i = 0; i < 3; i++) exp_q.push_back(model[i]);
    pci_access(4'hC, 32'h8000_0000, 1'b0, 3, 4'h0, 0);
    check("rdb_done", 32'(r_done), 32'd3);
    check("rdb_a1", 32'(r_a1), 32'b101);
    check("rdb_lat", 32'(r_first), 32'd1);
    check("rdb_ws", 32'(r_last - r_first), 32'd2);
    check("rdb_nostop", 32'(r_stop), 32'd0);

    // read burst crossing the region end, then a misaligned start
    for (int i = 13; i < 16; i++) exp_q.push_back(model[i]);
    pci_access(4'hE, 32'h8000_0034, 1'b0, 4, 4'h0, 0);
    check("rde_done", 32'(r_done), 32'd3);
    check("rde_stop", 32'(r_stop), 32'd3);
    exp_q.push_back(model[1]);
    pci_access(4'h6, 32'h8000_0005, 1'b0, 2, 4'h0, 0);
    check("rdm_done", 32'(r_done), 32'd1);
    check("rdm_stop", 32'(r_stop), 32'd1);

    // misses: wrong BAR window, then memory space disabled
    pci_access(4'h6, 32'h9000_0000, 1'b0, 1, 4'h0, 0);
    check("miss_bar", 32'(r_claim), 32'd0);
    cfg_wr(6'd1, 32'h0);
    pci_access(4'h6, 32'h8000_0000, 1'b0, 1, 4'h0, 0);
    check("miss_cmd", 32'(r_claim), 32'd0);
    cfg_wr(6'd1, 32'h0000_0002);

    // reset during the 2nd phase of a write burst clears everything
    wr_q = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    pci_access(4'h7, 32'h8000_0000, 1'b0, 4, 4'h0, 1);
    for (int i = 0; i < 16; i++) model[i] = '0;
    check("rst_regs", user_reg0, 32'h0);
    cfg_rd(6'd4, 32'h0);
    cfg_wr(6'd4, 32'h8000_0000);
    cfg_wr(6'd1, 32'h0000_0002);
    mem_wr(3, 32'hCAFE_F00D, 4'h0);
    exp_q.push_back(model[3]);
    pci_access(4'h6, 32'h8000_000C, 1'b0, 1, 4'h0, 0);
    check("post_rst_claim", 32'(r_claim), 32'd1);

`ifdef PCI_PARITY_EN
    cfg_wr(6'd1, 32'h0000_0042);
    frame_n = 1'b0; ad_in = 32'h8000_0008; cbe_in = 4'h7;
    tick();
    frame_n = 1'b1; irdy_n = 1'b0; ad_in = 32'h5A5A_0F0F; cbe_in = 4'h0; par_flip = 1'b1;
    check("par_trdy", 32'(trdy_n_out), 32'h0);
    tick();
    par_flip = 1'b0; irdy_n = 1'b1;
    check("perr_d1", 32'({perr_oe, perr_n_out}), 32'b01);
    tick();
    check("perr_d2", 32'({perr_oe, perr_n_out}), 32'b10);
    tick();
    check("perr_d3", 32'({perr_oe, perr_n_out}), 32'b11);
    tick();
    check("perr_d4", 32'(perr_oe), 32'h0);
    cfg_rd(6'd1, 32'h8000_0042);
    cfg_wr(6'd1, 32'h8000_0042);
    cfg_rd(6'd1, 32'h0000_0042);
`endif

    check("exp_q_empty", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
